// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned AWIDTH_DEF = 32;
  localparam int unsigned DWIDTH_DEF = 32;

  localparam logic [AWIDTH_DEF-1:0] RESET_PC_DEF = 32'h0100_0000;
  localparam logic [DWIDTH_DEF-1:0] NOP_INSN     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FULL,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [AWIDTH_DEF-1:0] pc;
    logic [DWIDTH_DEF-1:0] insn;
    logic                  valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: '0, insn: NOP_INSN, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise bubble.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wren,
  input  logic  flush,
  input  logic  load,
  input  ifid_t load_data,
  output ifid_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= IFID_BUBBLE;
    end else if (flush) begin
      q <= IFID_BUBBLE;
    end else if (wren) begin
      q <= load ? load_data : IFID_BUBBLE;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps one imem request in flight, and feeds IF/ID
// through a one-entry hold buffer when decode is stalled.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned           AWIDTH   = AWIDTH_DEF,
  parameter int unsigned           DWIDTH   = DWIDTH_DEF,
  parameter logic [AWIDTH-1:0]     RESET_PC = AWIDTH'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              ifid_wren,
  input  logic              ifid_flush,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  output logic [AWIDTH-1:0] d_pc_o,
  output logic [DWIDTH-1:0] d_insn_o,
  output logic              d_valid_o
);

  fetch_state_e      state_q;
  logic [AWIDTH-1:0] pc_q;
  logic [AWIDTH-1:0] req_pc_q;
  logic [AWIDTH-1:0] hold_pc_q;
  logic [DWIDTH-1:0] hold_insn_q;

  logic  deliver_now;
  logic  drain;
  logic  issue_ok;
  logic  ifid_load;
  ifid_t ifid_load_data;
  ifid_t ifid_q;

  // Issue/delivery decisions; the request strobe is gated off while in reset.
  always_comb begin
    deliver_now = (state_q == WAIT) && imem_rvalid_i && ifid_wren && !ifid_flush && !redirect_i;
    drain       = (state_q == FULL) && ifid_wren && !ifid_flush && !redirect_i;
    issue_ok    = rst_n && !stall_if && !redirect_i && ((state_q == IDLE) || deliver_now);
    imem_req_o  = issue_ok;
    imem_addr_o = issue_ok ? pc_q : '0;
    ifid_load   = deliver_now || drain;
    if (drain) begin
      ifid_load_data = '{pc: AWIDTH_DEF'(hold_pc_q), insn: DWIDTH_DEF'(hold_insn_q), valid: 1'b1};
    end else begin
      ifid_load_data = '{pc: AWIDTH_DEF'(req_pc_q), insn: DWIDTH_DEF'(imem_rdata_i), valid: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      hold_pc_q   <= '0;
      hold_insn_q <= NOP_INSN;
    end else begin
      // A redirect target is word-aligned and wins over sequential advance.
      if (redirect_i) begin
        pc_q <= redirect_pc_i & ~AWIDTH'(3);
      end else if (issue_ok) begin
        pc_q <= pc_q + AWIDTH'(4);
      end
      if (issue_ok) begin
        req_pc_q <= pc_q;
      end

      case (state_q)
        IDLE: begin
          if (issue_ok) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (ifid_flush || redirect_i) begin
              state_q <= IDLE;
            end else if (ifid_wren) begin
              state_q <= issue_ok ? WAIT : IDLE;
            end else begin
              state_q     <= FULL;
              hold_pc_q   <= req_pc_q;
              hold_insn_q <= imem_rdata_i;
            end
          end else if (redirect_i) begin
            state_q <= DISCARD;
          end
        end
        FULL: begin
          if (ifid_wren || ifid_flush || redirect_i) state_q <= IDLE;
        end
        DISCARD: begin
          if (imem_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .wren      (ifid_wren),
    .flush     (ifid_flush),
    .load      (ifid_load),
    .load_data (ifid_load_data),
    .q         (ifid_q)
  );

  assign d_pc_o    = AWIDTH'(ifid_q.pc);
  assign d_insn_o  = DWIDTH'(ifid_q.insn);
  assign d_valid_o = ifid_q.valid;

endmodule
